// File: rtl/latch_wr_pkg.sv
// Shared types and default sizing for the latch write scheduler.
package latch_wr_pkg;

    localparam int unsigned NREQ_DEF      = 4;
    localparam int unsigned NWORDS_DEF    = 8;
    localparam int unsigned DW_DEF        = 8;
    localparam int unsigned EN_CYCLES_DEF = 1;

    typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} wr_state_t;

endpackage

// File: rtl/latch_wr_sched_rr_arbiter.sv
// Request arbiter: rotating priority from ptr, or fixed lowest-index priority
// when LATCH_WR_FIXED_PRIO_EN is defined (ptr is then ignored).
module rr_arbiter
    import latch_wr_pkg::*;
#(
    parameter  int unsigned NREQ = NREQ_DEF,
    localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   winner
);

    int unsigned idx;
    logic        found;

`ifdef LATCH_WR_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

    // First asserted request scanning upward from the start index.
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef LATCH_WR_FIXED_PRIO_EN
            idx = i;
`else
            idx = (32'(ptr) + i) % NREQ;
`endif
            if (!found && req[IW'(idx)]) begin
                found              = 1'b1;
                grant[IW'(idx)]    = 1'b1;
                winner             = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/latch_wr_sched.sv
// Latch-bank write scheduler: arbitrate, then setup -> enable -> hold per write.
// Define LATCH_WR_FIXED_PRIO_EN for fixed lowest-index priority instead of round robin.
module latch_wr_sched
    import latch_wr_pkg::*;
#(
    parameter  int unsigned NREQ      = NREQ_DEF,
    parameter  int unsigned NWORDS    = NWORDS_DEF,
    parameter  int unsigned DW        = DW_DEF,
    parameter  int unsigned EN_CYCLES = EN_CYCLES_DEF,
    localparam int unsigned AW        = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic               wr_err,
    output logic [DW-1:0]      lat_d,
    output logic [NWORDS-1:0]  lat_en,
    output logic               busy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

    wr_state_t       state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   addr_q;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_winner;
    logic [IW-1:0]   ptr_in;
    logic            addr_oor;
    logic [NWORDS-1:0] en_dec;

`ifdef LATCH_WR_FIXED_PRIO_EN
    assign ptr_in = '0;
`else
    logic [IW-1:0] rr_ptr;
    assign ptr_in = rr_ptr;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req),
        .ptr    (ptr_in),
        .grant  (arb_grant),
        .winner (arb_winner)
    );

    // Out-of-range words still sequence, but never raise an enable.
    assign addr_oor = 32'(addr_q) >= NWORDS;
    assign en_dec   = addr_oor ? '0 : (NWORDS'(1) << addr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            grant_q <= '0;
            gnt     <= '0;
            wr_err  <= 1'b0;
            lat_d   <= '0;
            lat_en  <= '0;
            busy    <= 1'b0;
`ifndef LATCH_WR_FIXED_PRIO_EN
            rr_ptr  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state   <= SETUP;
                        busy    <= 1'b1;
                        grant_q <= arb_grant;
                        addr_q  <= req_addr[arb_winner*AW +: AW];
                        lat_d   <= req_data[arb_winner*DW +: DW];
`ifndef LATCH_WR_FIXED_PRIO_EN
                        rr_ptr  <= IW'((32'(arb_winner) + 32'd1) % NREQ);
`endif
                    end
                end
                SETUP: begin
                    state  <= ENABLE;
                    lat_en <= en_dec;
                    cnt    <= CW'(EN_CYCLES - 1);
                end
                ENABLE: begin
                    if (cnt == '0) begin
                        state  <= HOLD;
                        lat_en <= '0;
                        gnt    <= grant_q;
                        wr_err <= addr_oor;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                HOLD: begin
                    state  <= IDLE;
                    gnt    <= '0;
                    wr_err <= 1'b0;
                    busy   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_latch_wr_sched.sv
// Bench for latch_wr_sched: three configurations share one stimulus bus;
// a transaction-level model predicts winners and per-phase outputs.
module tb_latch_wr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] req_addr;
    logic [31:0] req_data;

    logic [3:0] gnt_a, gnt_b, gnt_c;
    logic       err_a, err_b, err_c;
    logic [7:0] d_a, d_b, d_c;
    logic [7:0] en_a, en_b;
    logic [5:0] en_c;
    logic       busy_a, busy_b, busy_c;

    always #5 clk = ~clk;

    latch_wr_sched dut_a (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt_a), .wr_err(err_a), .lat_d(d_a), .lat_en(en_a), .busy(busy_a)
    );

    latch_wr_sched #(.EN_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt_b), .wr_err(err_b), .lat_d(d_b), .lat_en(en_b), .busy(busy_b)
    );

    latch_wr_sched #(.NWORDS(6)) dut_c (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt_c), .wr_err(err_c), .lat_d(d_c), .lat_en(en_c), .busy(busy_c)
    );

    int vectors = 0;
    int miscompares = 0;
    int sel = 0;
    int ptr_m = 0;
    logic [2:0] av [4];
    logic [7:0] dv [4];
    logic [21:0] obs;

    // Observation word: {gnt, wr_err, busy, lat_en, lat_d}
    always_comb begin
        case (sel)
            1:       obs = {gnt_b, err_b, busy_b, en_b, d_b};
            2:       obs = {gnt_c, err_c, busy_c, 2'b00, en_c, d_c};
            default: obs = {gnt_a, err_a, busy_a, en_a, d_a};
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_inputs();
        for (int i = 0; i < 4; i++) begin
            req_addr[i*3 +: 3] = av[i];
            req_data[i*8 +: 8] = dv[i];
        end
    endtask

    function automatic int model_pick(input logic [3:0] r);
`ifdef LATCH_WR_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
        for (int i = 0; i < 4; i++) if (r[(ptr_m + i) % 4]) return (ptr_m + i) % 4;
`endif
        return -1;
    endfunction

    function automatic void model_advance(input int w);
`ifndef LATCH_WR_FIXED_PRIO_EN
        ptr_m = (w + 1) % 4;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
        ptr_m = 0;
    endtask

    // Walk one write from its arbitration edge through the return to IDLE.
    task automatic check_txn(input string tag, input int w, input logic [2:0] a,
                             input logic [7:0] d, input int en, input int nw,
                             input bit drop, input bit rel);
        logic [21:0] exp;
        logic [7:0]  en_exp;
        logic [3:0]  g;
        en_exp = 8'h00;
        if (int'(a) < nw) en_exp[a] = 1'b1;
        g = 4'b0001;
        g = g << w;
        tick();
        exp = {4'b0000, 1'b0, 1'b1, 8'h00, d};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s setup: got %h expected %h", tag, obs, exp);
        end
        if (drop) begin
            req[w] = 1'b0;
            av[w]  = 3'($urandom);
            dv[w]  = ~d;
            pack_inputs();
        end
        for (int i = 0; i < en; i++) begin
            tick();
            exp = {4'b0000, 1'b0, 1'b1, en_exp, d};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL %s enable[%0d]: got %h expected %h", tag, i, obs, exp);
            end
        end
        tick();
        exp = {g, (int'(a) >= nw), 1'b1, 8'h00, d};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s hold: got %h expected %h", tag, obs, exp);
        end
        if (rel) req[w] = 1'b0;
        tick();
        exp = {4'b0000, 1'b0, 1'b0, 8'h00, d};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s idle: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        tick();
        req = 4'b0000;
        tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            vectors++;
            if (obs !== 22'h0) begin
                miscompares++;
                $display("FAIL reset dut%0d: got %h expected %h", s, obs, 22'h0);
            end
        end
        rst = 1'b0;
        ptr_m = 0;
        sel = 0;
    endtask

    task automatic test_single();
        int cyc;
        do_reset();
        sel = 0;
        av[0] = 3'd3;
        dv[0] = 8'hA5;
        pack_inputs();
        req = 4'b0001;
        cyc = 1;
        model_advance(0);
        check_txn("single", 0, 3'd3, 8'hA5, 1, 8, 1'b0, 1'b1);
        req = 4'b0000;
        do_reset();
        av[0] = 3'd3;
        pack_inputs();
        req = 4'b0001;
        while (gnt_a === 4'b0000 && cyc < 20) begin
            tick();
            cyc++;
        end
        vectors++;
        if (cyc != 4) begin
            miscompares++;
            $display("FAIL single_latency: got %0d cycles expected %0d", cyc, 4);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_contention();
        int w;
        do_reset();
        sel = 0;
        for (int i = 0; i < 4; i++) begin
            av[i] = 3'($urandom);
            dv[i] = 8'($urandom);
        end
        pack_inputs();
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            w = model_pick(req);
            model_advance(w);
            check_txn("contention", w, av[w], dv[w], 1, 8, 1'b0, 1'b0);
        end
        req = 4'b0000;
    endtask

    task automatic test_en_cycles();
        do_reset();
        sel = 1;
        av[0] = 3'd7;
        dv[0] = 8'h3C;
        pack_inputs();
        req = 4'b0001;
        model_advance(0);
        check_txn("en_cycles", 0, 3'd7, 8'h3C, 3, 8, 1'b0, 1'b1);
        sel = 0;
    endtask

    task automatic test_rst_mid();
        logic [21:0] exp;
        int w;
        do_reset();
        sel = 0;
        av[2] = 3'd5;
        dv[2] = 8'h5A;
        pack_inputs();
        req = 4'b0100;
        w = model_pick(req);
        model_advance(w);
        tick();
        tick();
        exp = {4'b0000, 1'b0, 1'b1, 8'b0010_0000, 8'h5A};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL rst_mid enable: got %h expected %h", obs, exp);
        end
        rst = 1'b1;
        req = 4'b0000;
        tick();
        vectors++;
        if (obs !== 22'h0) begin
            miscompares++;
            $display("FAIL rst_mid abort: got %h expected %h", obs, 22'h0);
        end
        rst = 1'b0;
        ptr_m = 0;
        av[1] = 3'd1;
        dv[1] = 8'hC3;
        av[3] = 3'd2;
        dv[3] = 8'h96;
        pack_inputs();
        req = 4'b1010;
        w = model_pick(req);
        model_advance(w);
        check_txn("rst_mid_after", w, av[w], dv[w], 1, 8, 1'b0, 1'b1);
        req = 4'b0000;
    endtask

    task automatic test_out_of_range();
        logic [2:0] addrs [3];
        addrs[0] = 3'd6;
        addrs[1] = 3'd7;
        addrs[2] = 3'd5;
        do_reset();
        sel = 2;
        for (int i = 0; i < 3; i++) begin
            av[1] = addrs[i];
            dv[1] = 8'($urandom);
            pack_inputs();
            req = 4'b0010;
            model_advance(1);
            check_txn("out_of_range", 1, av[1], dv[1], 1, 6, 1'b0, 1'b1);
        end
        sel = 0;
    endtask

    task automatic test_prio();
        int w;
        do_reset();
        sel = 0;
        for (int i = 0; i < 4; i++) begin
            av[i] = 3'($urandom);
            dv[i] = 8'($urandom);
        end
        pack_inputs();
        req = 4'b1010;
        for (int t = 0; t < 4; t++) begin
            w = model_pick(req);
            model_advance(w);
            check_txn("prio", w, av[w], dv[w], 1, 8, 1'b0, 1'b0);
        end
        req[1] = 1'b0;
        w = model_pick(req);
        model_advance(w);
        check_txn("prio_drop", w, av[w], dv[w], 1, 8, 1'b0, 1'b1);
        req = 4'b0000;
    endtask

    task automatic test_random();
        int w;
        do_reset();
        sel = 0;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    req[i] = 1'b1;
                    av[i]  = 3'($urandom);
                    dv[i]  = 8'($urandom);
                end else if (req[i] && $urandom_range(0, 7) == 0) begin
                    req[i] = 1'b0;
                end
            end
            if (req == 4'b0000) begin
                req[t % 4] = 1'b1;
                av[t % 4]  = 3'($urandom);
                dv[t % 4]  = 8'($urandom);
            end
            pack_inputs();
            w = model_pick(req);
            model_advance(w);
            check_txn("random", w, av[w], dv[w], 1, 8, 1'($urandom_range(0, 1)), 1'b1);
        end
        req = 4'b0000;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < 4; i++) begin
            av[i] = '0;
            dv[i] = '0;
        end
        test_reset();
        test_single();
        test_contention();
        test_en_cycles();
        test_rst_mid();
        test_out_of_range();
        test_prio();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
